// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores to the data SRAM over req/addr_ok/data_ok,
// aligns store data, extracts load data and builds the MEM->WB bus.
module mem_stage #(
  parameter int DM_AW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_valid,
  input  logic [161:0]      EXE_MEM_bus_r,
  input  logic              WB_allow_in,
  input  logic              mem_flush,
  output logic              MEM_over,
  output logic [123:0]      MEM_WB_bus,
  output logic [4:0]        MEM_wdest,
  output logic              MEM_rf_wen,
  output logic [31:0]       MEM_pc,
  output logic              dm_req,
  output logic              dm_wr,
  output logic [3:0]        dm_wstrb,
  output logic [DM_AW-1:0]  dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_addr_ok,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_data_ok,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic [7:0]  mem_control;
  logic [31:0] store_data;
  logic [31:0] exe_result;
  logic [89:0] pass;

  assign {mem_control, store_data, exe_result, pass} = EXE_MEM_bus_r;

  // A simultaneous load+store request is resolved as a store.
  logic       is_store, is_load, load_sign;
  logic [1:0] size;
  logic       sz_byte, sz_half, sz_word;
  logic [1:0] addr_lo;
  logic       misalign, mem_ok_op, start;
  logic       adel, ades;
  logic       unused_ctrl;

  assign is_store    = mem_control[6];
  assign is_load     = mem_control[7] & ~mem_control[6];
  assign size        = mem_control[5:4];
  assign load_sign   = mem_control[3];
  assign unused_ctrl = ^mem_control[2:0];

  assign sz_byte  = (size == 2'b00);
  assign sz_half  = (size == 2'b01);
  assign sz_word  = size[1];
  assign addr_lo  = exe_result[1:0];
  assign misalign = (sz_half & addr_lo[0]) | (sz_word & (addr_lo != 2'b00));
  assign adel     = is_load & misalign;
  assign ades     = is_store & misalign;

  assign mem_ok_op = (is_load | is_store) & ~misalign;
  assign start     = MEM_valid & mem_ok_op & ~mem_flush;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = dm_addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        if (dm_addr_ok)     state_d = S_WAIT;
        else if (mem_flush) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (dm_data_ok) begin
          if (mem_flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            rdata_d = dm_rdata;
          end
        end else if (mem_flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (WB_allow_in | mem_flush) state_d = S_IDLE;
      end
      S_DRAIN: begin
        // The flushed access still owes one response; swallow it.
        if (dm_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    dm_req   = 1'b0;
    MEM_over = 1'b0;
    case (state_q)
      S_IDLE: begin
        dm_req   = start;
        MEM_over = MEM_valid & ~mem_flush & ~mem_ok_op;
      end
      S_REQ:   dm_req   = MEM_valid;
      S_DONE:  MEM_over = MEM_valid & ~mem_flush;
      default: ;
    endcase
  end

  // Store alignment
  logic [3:0] strb;
  always_comb begin
    strb     = 4'b1111;
    dm_wdata = store_data;
    if (sz_byte) begin
      strb     = 4'b0001 << addr_lo;
      dm_wdata = {4{store_data[7:0]}};
    end else if (sz_half) begin
      strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
      dm_wdata = {2{store_data[15:0]}};
    end
  end

  assign dm_wr    = is_store;
  assign dm_wstrb = is_store ? strb : 4'b0000;
  assign dm_addr  = exe_result[DM_AW-1:0];

  // Load extraction from the captured response
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val, mem_result;

  assign byte_lane = rdata_q[{addr_lo, 3'b000} +: 8];
  assign half_lane = addr_lo[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_val = rdata_q;
    if (sz_byte)      load_val = {{24{load_sign & byte_lane[7]}}, byte_lane};
    else if (sz_half) load_val = {{16{load_sign & half_lane[15]}}, half_lane};
  end

  assign mem_result = (state_q == S_DONE && is_load) ? load_val : exe_result;

  assign MEM_WB_bus  = {mem_result, pass, adel, ades};
  assign MEM_wdest   = pass[40:36] & {5{MEM_valid}};
  assign MEM_rf_wen  = pass[41];
  assign MEM_pc      = pass[31:0];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of directed operations, randomized operations checked
// against an arithmetic reference model, and hand sequences for flush and reset.
module tb_mem_stage;

  logic          clk = 1'b0;
  logic          reset;
  logic          MEM_valid;
  logic [161:0]  EXE_MEM_bus_r;
  logic          WB_allow_in;
  logic          mem_flush;
  logic          MEM_over;
  logic [123:0]  MEM_WB_bus;
  logic [4:0]    MEM_wdest;
  logic          MEM_rf_wen;
  logic [31:0]   MEM_pc;
  logic          dm_req;
  logic          dm_wr;
  logic [3:0]    dm_wstrb;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_addr_ok;
  logic [31:0]   dm_rdata;
  logic          dm_data_ok;
  logic [2:0]    dbg_state;

  mem_stage #(.DM_AW(32)) dut (
    .clk(clk), .reset(reset), .MEM_valid(MEM_valid), .EXE_MEM_bus_r(EXE_MEM_bus_r),
    .WB_allow_in(WB_allow_in), .mem_flush(mem_flush), .MEM_over(MEM_over),
    .MEM_WB_bus(MEM_WB_bus), .MEM_wdest(MEM_wdest), .MEM_rf_wen(MEM_rf_wen),
    .MEM_pc(MEM_pc), .dm_req(dm_req), .dm_wr(dm_wr), .dm_wstrb(dm_wstrb),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_addr_ok(dm_addr_ok),
    .dm_rdata(dm_rdata), .dm_data_ok(dm_data_ok), .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  localparam logic [7:0] OP_ALU = 8'h00, OP_LW = 8'hA0, OP_LB = 8'h88, OP_LBU = 8'h80,
                         OP_LH = 8'h98, OP_LHU = 8'h90, OP_SW = 8'h60, OP_SH = 8'h50,
                         OP_SB = 8'h40, OP_LDST = 8'hE0;

  typedef struct {
    bit          mem;
    bit          wr;
    bit          adel;
    bit          ades;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] result;
  } exp_t;

  typedef struct {
    string       nm;
    logic [7:0]  mc;
    logic [31:0] sd;
    logic [31:0] exe;
    logic [31:0] rd;
    int          a_lat;
    int          d_lat;
    int          stall;
    exp_t        e;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  vec_t vec_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic exp_t mk_e(input bit mem, input bit wr, input bit adel, input bit ades,
                                input logic [3:0] wstrb, input logic [31:0] wdata,
                                input logic [31:0] result);
    exp_t e;
    e.mem = mem; e.wr = wr; e.adel = adel; e.ades = ades;
    e.wstrb = wstrb; e.wdata = wdata; e.result = result;
    return e;
  endfunction

  // Reference model: sizes as byte counts, lanes by shifting and modulo.
  function automatic exp_t model(input logic [7:0] mc, input logic [31:0] sd,
                                 input logic [31:0] exe, input logic [31:0] rd);
    exp_t e;
    bit st, ld, mis;
    int nb, off;
    longint unsigned range, v, rep;
    st  = mc[6];
    ld  = mc[7] && !mc[6];
    nb  = (mc[5:4] == 2'd0) ? 1 : (mc[5:4] == 2'd1) ? 2 : 4;
    off = int'(exe[1:0]);
    mis = (off % nb) != 0;
    range = 64'd1 << (8 * nb);
    rep   = (nb == 1) ? 64'h01010101 : (nb == 2) ? 64'h00010001 : 64'd1;
    e.mem   = (ld || st) && !mis;
    e.wr    = st;
    e.adel  = ld && mis;
    e.ades  = st && mis;
    e.wstrb = st ? 4'(((1 << nb) - 1) << off) : 4'd0;
    e.wdata = 32'((64'(sd) % range) * rep);
    v = (64'(rd) >> (8 * off)) % range;
    if (mc[3] && nb < 4 && v >= range / 2) v = v + (64'h1_0000_0000 - range);
    e.result = (ld && !mis) ? 32'(v) : exe;
    return e;
  endfunction

  task automatic add_vec(input string nm, input logic [7:0] mc, input logic [31:0] sd,
                         input logic [31:0] exe, input logic [31:0] rd, input int a_lat,
                         input int d_lat, input int stall, input exp_t e);
    vec_t v;
    v.nm = nm; v.mc = mc; v.sd = sd; v.exe = exe; v.rd = rd;
    v.a_lat = a_lat; v.d_lat = d_lat; v.stall = stall; v.e = e;
    vec_q.push_back(v);
  endtask

  task automatic drive_idle();
    MEM_valid   = 1'b0;
    WB_allow_in = 1'b1;
    mem_flush   = 1'b0;
    dm_addr_ok  = 1'b0;
    dm_data_ok  = 1'b0;
    dm_rdata    = $urandom;
  endtask

  // Drives one instruction through MEM with the given SRAM timing and checks each cycle.
  task automatic do_op(input string nm, input logic [7:0] mc, input logic [31:0] sd,
                       input logic [31:0] exe, input logic [31:0] rd, input int a_lat,
                       input int d_lat, input int stall, input exp_t e);
    logic [89:0] pass;
    logic [31:0] exp_res;
    int done_c, last_c, data_c;
    pass   = {26'($urandom), $urandom, $urandom};
    data_c = a_lat + d_lat;
    done_c = e.mem ? data_c + 1 : 0;
    last_c = done_c + stall;
    exp_q.push_back(e.result);
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      MEM_valid     = 1'b1;
      EXE_MEM_bus_r = {mc, sd, exe, pass};
      mem_flush     = 1'b0;
      WB_allow_in   = (c == last_c);
      dm_addr_ok    = e.mem && (c == a_lat);
      dm_data_ok    = e.mem && ((c == data_c) || (c >= done_c && $urandom_range(0, 1) == 1));
      dm_rdata      = (e.mem && c == data_c) ? rd : $urandom;
      #1;
      if (e.mem && c <= a_lat) begin
        chk({nm, ".req"}, 128'(dm_req), 128'(1));
        if (c == a_lat) begin
          chk({nm, ".addr"}, 128'(dm_addr), 128'(exe));
          chk({nm, ".wr"}, 128'(dm_wr), 128'(e.wr));
          chk({nm, ".wstrb"}, 128'(dm_wstrb), 128'(e.wstrb));
          if (e.wr) chk({nm, ".wdata"}, 128'(dm_wdata), 128'(e.wdata));
        end
      end else begin
        chk({nm, ".noreq"}, 128'(dm_req), 128'(0));
      end
      chk({nm, ".over"}, 128'(MEM_over), 128'(c >= done_c));
      if (c == 0) begin
        chk({nm, ".wdest"}, 128'(MEM_wdest), 128'(pass[40:36]));
        chk({nm, ".rf_wen"}, 128'(MEM_rf_wen), 128'(pass[41]));
        chk({nm, ".pc"}, 128'(MEM_pc), 128'(pass[31:0]));
      end
      if (c == last_c) begin
        exp_res = exp_q.pop_front();
        chk({nm, ".result"}, 128'(MEM_WB_bus[123:92]), 128'(exp_res));
        chk({nm, ".pass"}, 128'(MEM_WB_bus[91:2]), 128'(pass));
        chk({nm, ".adel"}, 128'(MEM_WB_bus[1]), 128'(e.adel));
        chk({nm, ".ades"}, 128'(MEM_WB_bus[0]), 128'(e.ades));
      end
    end
    // Bubble with a stray response that must be ignored.
    @(negedge clk);
    drive_idle();
    dm_data_ok = ($urandom_range(0, 1) == 1);
    #1;
    chk({nm, ".gap_req"}, 128'(dm_req), 128'(0));
    chk({nm, ".gap_over"}, 128'(MEM_over), 128'(0));
    chk({nm, ".gap_wdest"}, 128'(MEM_wdest), 128'(0));
  endtask

  initial begin
    logic [7:0] ops[10];
    logic [7:0] mc;
    logic [31:0] sd, exe, rd;

    // Reset
    drive_idle();
    EXE_MEM_bus_r = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.req", 128'(dm_req), 128'(0));
    chk("reset.over", 128'(MEM_over), 128'(0));
    chk("reset.wdest", 128'(MEM_wdest), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    add_vec("alu",     OP_ALU,  32'h0,        32'h12345678, 32'h0,        0, 0, 1, mk_e(0, 0, 0, 0, 4'h0, 32'h0, 32'h12345678));
    add_vec("lw",      OP_LW,   32'h0,        32'h100,      32'hDEADBEEF, 2, 3, 2, mk_e(1, 0, 0, 0, 4'h0, 32'h0, 32'hDEADBEEF));
    add_vec("lb",      OP_LB,   32'h0,        32'h103,      32'h80123456, 0, 1, 0, mk_e(1, 0, 0, 0, 4'h0, 32'h0, 32'hFFFFFF80));
    add_vec("lbu",     OP_LBU,  32'h0,        32'h103,      32'h80123456, 0, 1, 0, mk_e(1, 0, 0, 0, 4'h0, 32'h0, 32'h00000080));
    add_vec("sh",      OP_SH,   32'h0000ABCD, 32'h202,      32'h0,        1, 2, 0, mk_e(1, 1, 0, 0, 4'b1100, 32'hABCDABCD, 32'h202));
    add_vec("lw_mis",  OP_LW,   32'h0,        32'h101,      32'h0,        0, 0, 0, mk_e(0, 0, 1, 0, 4'h0, 32'h0, 32'h101));
    add_vec("sw_mis",  OP_SW,   32'h11111111, 32'h101,      32'h0,        0, 0, 0, mk_e(0, 1, 0, 1, 4'h0, 32'h0, 32'h101));
    add_vec("lh",      OP_LH,   32'h0,        32'h102,      32'h80017FFF, 1, 1, 1, mk_e(1, 0, 0, 0, 4'h0, 32'h0, 32'hFFFF8001));
    add_vec("lhu",     OP_LHU,  32'h0,        32'h100,      32'h8001F00F, 0, 2, 0, mk_e(1, 0, 0, 0, 4'h0, 32'h0, 32'h0000F00F));
    add_vec("sb",      OP_SB,   32'h123456A5, 32'h101,      32'h0,        0, 1, 1, mk_e(1, 1, 0, 0, 4'b0010, 32'hA5A5A5A5, 32'h101));
    add_vec("ldst",    OP_LDST, 32'hCAFEF00D, 32'h104,      32'hFFFFFFFF, 0, 1, 0, mk_e(1, 1, 0, 0, 4'b1111, 32'hCAFEF00D, 32'h104));
    add_vec("lh_mis",  OP_LH,   32'h0,        32'h103,      32'h0,        0, 0, 0, mk_e(0, 0, 1, 0, 4'h0, 32'h0, 32'h103));
    add_vec("sh_mis",  OP_SH,   32'h1234,     32'h201,      32'h0,        0, 0, 0, mk_e(0, 1, 0, 1, 4'h0, 32'h0, 32'h201));
    add_vec("lb_pos",  OP_LB,   32'h0,        32'h102,      32'h11227F44, 0, 1, 0, mk_e(1, 0, 0, 0, 4'h0, 32'h0, 32'h00000022));
    add_vec("sw",      OP_SW,   32'h0BADF00D, 32'h3FC,      32'h0,        3, 1, 0, mk_e(1, 1, 0, 0, 4'b1111, 32'h0BADF00D, 32'h3FC));
    foreach (vec_q[i])
      do_op(vec_q[i].nm, vec_q[i].mc, vec_q[i].sd, vec_q[i].exe, vec_q[i].rd,
            vec_q[i].a_lat, vec_q[i].d_lat, vec_q[i].stall, vec_q[i].e);

    // Flush while waiting for data: drain the stale response, then a fresh load.
    @(negedge clk);
    MEM_valid = 1'b1; EXE_MEM_bus_r = {OP_LW, 32'h0, 32'h200, 90'h0};
    dm_addr_ok = 1'b1; dm_data_ok = 1'b0; WB_allow_in = 1'b0;
    #1; chk("drain.req", 128'(dm_req), 128'(1));
    @(negedge clk);
    dm_addr_ok = 1'b0; mem_flush = 1'b1;
    #1; chk("drain.flush_over", 128'(MEM_over), 128'(0));
    @(negedge clk);
    mem_flush = 1'b0; EXE_MEM_bus_r = {OP_LW, 32'h0, 32'h300, 90'h0};
    #1; chk("drain.hold_req", 128'(dm_req), 128'(0));
    chk("drain.hold_over", 128'(MEM_over), 128'(0));
    @(negedge clk);
    dm_data_ok = 1'b1; dm_rdata = 32'hBAD0BAD0;
    #1; chk("drain.stale_req", 128'(dm_req), 128'(0));
    chk("drain.stale_over", 128'(MEM_over), 128'(0));
    do_op("lw_after_drain", OP_LW, 32'h0, 32'h300, 32'h0300CAFE, 0, 1, 0,
          mk_e(1, 0, 0, 0, 4'h0, 32'h0, 32'h0300CAFE));

    // Flush while the request is still pending, then an ALU op completes at once.
    @(negedge clk);
    MEM_valid = 1'b1; EXE_MEM_bus_r = {OP_LW, 32'h0, 32'h500, 90'h0};
    dm_addr_ok = 1'b0; dm_data_ok = 1'b0; WB_allow_in = 1'b0;
    @(negedge clk);
    mem_flush = 1'b1;
    #1; chk("reqflush.over", 128'(MEM_over), 128'(0));
    do_op("alu_after_reqflush", OP_ALU, 32'h0, 32'h00C0FFEE, 32'h0, 0, 0, 0,
          mk_e(0, 0, 0, 0, 4'h0, 32'h0, 32'h00C0FFEE));

    // Flush coinciding with data_ok: response discarded, next load issues normally.
    @(negedge clk);
    MEM_valid = 1'b1; EXE_MEM_bus_r = {OP_LW, 32'h0, 32'h600, 90'h0};
    dm_addr_ok = 1'b1; WB_allow_in = 1'b0;
    @(negedge clk);
    dm_addr_ok = 1'b0; mem_flush = 1'b1; dm_data_ok = 1'b1; dm_rdata = 32'h66666666;
    #1; chk("dataflush.over", 128'(MEM_over), 128'(0));
    do_op("lw_after_dataflush", OP_LW, 32'h0, 32'h604, 32'h12121212, 1, 1, 0,
          mk_e(1, 0, 0, 0, 4'h0, 32'h0, 32'h12121212));

    // Reset in the middle of an access; a later data_ok must be ignored.
    @(negedge clk);
    MEM_valid = 1'b1; EXE_MEM_bus_r = {OP_LW, 32'h0, 32'h400, 90'h0};
    dm_addr_ok = 1'b1; WB_allow_in = 1'b0;
    #1; chk("rst_mid.req", 128'(dm_req), 128'(1));
    @(negedge clk);
    dm_addr_ok = 1'b0;
    #1; reset = 1'b1; MEM_valid = 1'b0;
    #1; chk("rst_mid.req_off", 128'(dm_req), 128'(0));
    chk("rst_mid.over_off", 128'(MEM_over), 128'(0));
    @(negedge clk);
    reset = 1'b0; dm_data_ok = 1'b1; dm_rdata = 32'h5A5A5A5A;
    #1; chk("rst_mid.stray_over", 128'(MEM_over), 128'(0));
    do_op("lw_after_reset", OP_LW, 32'h0, 32'h408, 32'h00ABCDEF, 0, 2, 1,
          mk_e(1, 0, 0, 0, 4'h0, 32'h0, 32'h00ABCDEF));

    // Randomized operations against the reference model
    ops = '{OP_ALU, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SH, OP_SB, OP_LDST};
    for (int i = 0; i < 80; i++) begin
      mc  = ops[$urandom_range(0, 9)];
      sd  = $urandom;
      exe = $urandom;
      rd  = $urandom;
      do_op($sformatf("rnd%0d", i), mc, sd, exe, rd, $urandom_range(0, 3),
            $urandom_range(1, 3), $urandom_range(0, 2), model(mc, sd, exe, rd));
    end

    chk("scoreboard.empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
